// File: rtl/sdram_probe_clear.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : sdram_probe_clear
//  Purpose  : Owns the single-port SDRAM controller command interface.
//             After reset it sizes the installed SDRAM by writing aliasing
//             signatures and reading them back, publishes the result on cfg,
//             then zero-fills the array. A single host requester shares the
//             port once probing is done and has priority over the sweep.
//  Ports    : clk_sys, RESET         - clock, synchronous active-high reset
//             mem_ready/mem_dout     - controller status and read data
//             mem_addr/din/we/rd     - controller command (1-cycle strobes)
//             cfg                    - [15] probe done, [2:0] size bits
//             clear_done             - zero-fill sweep finished (level)
//             host_req/we/addr/din   - host request, held until host_ack
//             host_ack/host_dout     - completion pulse and read data
//  Revision : 1.0 - initial release
// ============================================================================
module sdram_probe_clear #(
    parameter int CLR_AW   = 25,
    parameter bit CLEAR_EN = 1'b1
) (
    input  logic        clk_sys,
    input  logic        RESET,
    input  logic        mem_ready,
    input  logic [15:0] mem_dout,
    output logic [26:0] mem_addr,
    output logic [15:0] mem_din,
    output logic        mem_we,
    output logic        mem_rd,
    output logic [15:0] cfg,
    output logic        clear_done,
    input  logic        host_req,
    input  logic        host_we,
    input  logic [26:0] host_addr,
    input  logic [15:0] host_din,
    output logic        host_ack,
    output logic [15:0] host_dout
);

    // Signature addresses: each lands on a different SDRAM size boundary.
    localparam logic [26:0] ADDR_64M = 27'h4000000;
    localparam logic [26:0] ADDR_32M = 27'h2000000;
    localparam logic [26:0] ADDR_0   = 27'h0000000;
    localparam logic [26:0] ADDR_16M = 27'h1000000;
    localparam logic [15:0] SIG_64M  = 16'd3128;
    localparam logic [15:0] SIG_32M  = 16'd2064;
    localparam logic [15:0] SIG_0    = 16'd1032;
    localparam logic [15:0] SIG_16M  = 16'd12345;

    typedef enum logic [2:0] {
        WAIT0 = 3'd0,
        ISSUE = 3'd1,
        GAP   = 3'd2,
        DONE  = 3'd3,
        IDLE  = 3'd4
    } state_t;

    state_t          state_q;
    logic [2:0]      step_q;        // probe command index 0..6
    logic [CLR_AW:0] clr_q;         // MSB set = sweep finished
    logic            op_host_q;     // command in flight belongs to the host
    logic            op_we_q;
    logic [26:0]     mem_addr_q;
    logic [15:0]     mem_din_q;
    logic            mem_we_q;
    logic            mem_rd_q;
    logic            probe_done_q;
    logic [2:0]      size_q;
    logic            clear_done_q;
    logic            host_ack_q;
    logic [15:0]     host_dout_q;

    logic [CLR_AW:0] clr_d;
    logic            host_go_d;
    logic            clr_pend_d;
    logic [26:0]     probe_addr_d;
    logic [15:0]     probe_din_d;
    logic            probe_we_d;

    assign clr_d      = clr_q + {{CLR_AW{1'b0}}, 1'b1};
    // A request still high during its own ack cycle is the old request;
    // masking with host_ack_q keeps it from being served twice.
    assign host_go_d  = probe_done_q && host_req && !host_ack_q;
    assign clr_pend_d = CLEAR_EN && !clr_q[CLR_AW];
    assign probe_we_d = (step_q < 3'd4);

    always_comb begin
        probe_addr_d = ADDR_0;
        probe_din_d  = 16'd0;
        case (step_q)
            3'd0: begin probe_addr_d = ADDR_64M; probe_din_d = SIG_64M; end
            3'd1: begin probe_addr_d = ADDR_32M; probe_din_d = SIG_32M; end
            3'd2: begin probe_addr_d = ADDR_0;   probe_din_d = SIG_0;   end
            3'd3: begin probe_addr_d = ADDR_16M; probe_din_d = SIG_16M; end
            3'd4: probe_addr_d = ADDR_64M;
            3'd5: probe_addr_d = ADDR_32M;
            default: probe_addr_d = ADDR_0;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (RESET) begin
            state_q      <= WAIT0;
            step_q       <= 3'd0;
            clr_q        <= '0;
            op_host_q    <= 1'b0;
            op_we_q      <= 1'b0;
            mem_addr_q   <= '0;
            mem_din_q    <= '0;
            mem_we_q     <= 1'b0;
            mem_rd_q     <= 1'b0;
            probe_done_q <= 1'b0;
            size_q       <= 3'd0;
            clear_done_q <= 1'b0;
            host_ack_q   <= 1'b0;
            host_dout_q  <= '0;
        end else begin
            mem_we_q   <= 1'b0;
            mem_rd_q   <= 1'b0;
            host_ack_q <= 1'b0;
            case (state_q)
                // WAIT0 shares the issue path so the first probe strobe
                // follows the first mem_ready by one cycle.
                WAIT0, ISSUE, IDLE: begin
                    if (mem_ready) begin
                        if (host_go_d) begin
                            mem_addr_q <= host_addr;
                            mem_din_q  <= host_din;
                            mem_we_q   <= host_we;
                            mem_rd_q   <= !host_we;
                            op_host_q  <= 1'b1;
                            op_we_q    <= host_we;
                            state_q    <= GAP;
                        end else if (!probe_done_q) begin
                            mem_addr_q <= probe_addr_d;
                            mem_din_q  <= probe_din_d;
                            mem_we_q   <= probe_we_d;
                            mem_rd_q   <= !probe_we_d;
                            op_host_q  <= 1'b0;
                            op_we_q    <= probe_we_d;
                            state_q    <= GAP;
                        end else if (clr_pend_d) begin
                            mem_addr_q <= 27'(clr_q[CLR_AW-1:0]);
                            mem_din_q  <= 16'd0;
                            mem_we_q   <= 1'b1;
                            op_host_q  <= 1'b0;
                            op_we_q    <= 1'b1;
                            state_q    <= GAP;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                // Controller may not have dropped mem_ready yet.
                GAP: state_q <= DONE;
                DONE: begin
                    if (mem_ready) begin
                        state_q <= ISSUE;
                        if (op_host_q) begin
                            host_ack_q <= 1'b1;
                            if (!op_we_q) begin
                                host_dout_q <= mem_dout;
                            end
                        end else if (!probe_done_q) begin
                            step_q <= step_q + 3'd1;
                            case (step_q)
                                3'd4: size_q[2] <= (mem_dout == SIG_64M);
                                3'd5: size_q[1] <= (mem_dout == SIG_32M);
                                3'd6: begin
                                    size_q[0]    <= (mem_dout == SIG_0);
                                    probe_done_q <= 1'b1;
                                    if (!CLEAR_EN) begin
                                        clear_done_q <= 1'b1;
                                    end
                                end
                                default: ;
                            endcase
                        end else begin
                            // Sweep advances only on its own completions.
                            clr_q <= clr_d;
                            if (clr_d[CLR_AW]) begin
                                clear_done_q <= 1'b1;
                            end
                        end
                    end
                end
                default: state_q <= WAIT0;
            endcase
        end
    end

    assign mem_addr   = mem_addr_q;
    assign mem_din    = mem_din_q;
    assign mem_we     = mem_we_q;
    assign mem_rd     = mem_rd_q;
    assign cfg        = {probe_done_q, 12'd0, size_q};
    assign clear_done = clear_done_q;
    assign host_ack   = host_ack_q;
    assign host_dout  = host_dout_q;

endmodule
`default_nettype wire

// File: tb/tb_sdram_probe_clear.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_sdram_probe_clear
//  Purpose  : Directed self-checking bench for sdram_probe_clear with an
//             SDRAM controller model (3-cycle busy, selectable address
//             decode width or stuck-at-0xFFFF read data).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sdram_probe_clear;

    localparam int CLR_AW = 4;

    logic        clk_sys = 1'b0;
    logic        RESET   = 1'b1;
    logic        mem_ready;
    logic [15:0] mem_dout = 16'd0;
    logic [26:0] mem_addr;
    logic [15:0] mem_din;
    logic        mem_we;
    logic        mem_rd;
    logic [15:0] cfg;
    logic        clear_done;
    logic        host_req  = 1'b0;
    logic        host_we   = 1'b0;
    logic [26:0] host_addr = 27'd0;
    logic [15:0] host_din  = 16'd0;
    logic        host_ack;
    logic [15:0] host_dout;

    always #5 clk_sys = ~clk_sys;

    sdram_probe_clear #(.CLR_AW(CLR_AW), .CLEAR_EN(1'b1)) dut (
        .clk_sys    (clk_sys),
        .RESET      (RESET),
        .mem_ready  (mem_ready),
        .mem_dout   (mem_dout),
        .mem_addr   (mem_addr),
        .mem_din    (mem_din),
        .mem_we     (mem_we),
        .mem_rd     (mem_rd),
        .cfg        (cfg),
        .clear_done (clear_done),
        .host_req   (host_req),
        .host_we    (host_we),
        .host_addr  (host_addr),
        .host_din   (host_din),
        .host_ack   (host_ack),
        .host_dout  (host_dout)
    );

    // ---------------- controller model ----------------
    logic        m_ready  = 1'b1;
    logic [1:0]  busy     = 2'd0;
    logic        hold     = 1'b1;
    logic        wipe     = 1'b0;
    logic [1:0]  dec_mode = 2'd0;   // 0: 27b, 1: 26b, 2: 25b, 3: reads 0xFFFF
    logic [15:0] mm [512];

    assign mem_ready = m_ready & ~hold;

    function automatic logic [8:0] idx(input logic [26:0] a, input logic [1:0] m);
        logic [26:0] k;
        case (m)
            2'd1:    k = a & 27'h3FFFFFF;
            2'd2:    k = a & 27'h1FFFFFF;
            default: k = a;
        endcase
        return {k[26:24], k[5:0]};
    endfunction

    always @(posedge clk_sys) begin
        if (wipe) begin
            for (int i = 0; i < 512; i++) mm[i] <= 16'hA5A5;
        end
        if (mem_we || mem_rd) begin
            m_ready <= 1'b0;
            busy    <= 2'd3;
            if (mem_we) mm[idx(mem_addr, dec_mode)] <= mem_din;
            else        mem_dout <= (dec_mode == 2'd3) ? 16'hFFFF : mm[idx(mem_addr, dec_mode)];
        end else if (busy != 2'd0) begin
            busy <= busy - 2'd1;
            if (busy == 2'd1) m_ready <= 1'b1;
        end
    end

    // ---------------- command / ack monitor ----------------
    typedef struct packed {
        logic        we;
        logic [26:0] addr;
        logic [15:0] din;
    } ent_t;

    ent_t log_q[$];
    int   ack_cnt = 0;

    always @(posedge clk_sys) begin
        if (RESET) begin
            log_q.delete();
            ack_cnt <= 0;
        end else begin
            if (mem_we || mem_rd) log_q.push_back({mem_we, mem_addr, mem_din});
            if (host_ack) ack_cnt <= ack_cnt + 1;
        end
    end

    // ---------------- checking ----------------
    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [43:0] ent(input int i);
        ent_t e;
        e = log_q[i];
        return e;
    endfunction

    task automatic run_probe(input logic [1:0] mode, input logic [15:0] exp_cfg, input string tag);
        int n;
        @(negedge clk_sys);
        RESET = 1'b1; hold = 1'b1; wipe = 1'b1; dec_mode = mode;
        @(negedge clk_sys);
        wipe = 1'b0;
        @(negedge clk_sys);
        check({tag, " rst cfg"}, 64'(cfg), 64'd0);
        check({tag, " rst clear_done"}, 64'(clear_done), 64'd0);
        check({tag, " rst strobes"}, 64'({mem_we, mem_rd, host_ack}), 64'd0);
        check({tag, " rst mem_addr"}, 64'(mem_addr), 64'd0);
        RESET = 1'b0;
        repeat (3) @(negedge clk_sys);
        check({tag, " wait0 quiet"}, 64'({mem_we, mem_rd}), 64'd0);
        hold = 1'b0;
        @(negedge clk_sys);
        check({tag, " first strobe"}, 64'({mem_we, mem_rd, mem_addr, mem_din}),
              64'({1'b1, 1'b0, 27'h4000000, 16'd3128}));
        n = 0;
        while (!cfg[15] && n < 300) begin
            @(negedge clk_sys);
            n++;
        end
        check({tag, " probe done"}, 64'(cfg[15]), 64'd1);
        check({tag, " cfg"}, 64'(cfg), 64'(exp_cfg));
        check({tag, " probe cmds"}, 64'(log_q.size()), 64'd7);
    endtask

    initial begin
        int  n;
        bit  raised;

        // ---- A: full decode, host read injected mid-sweep ----
        run_probe(2'd0, 16'h8007, "A");
        raised = 1'b0;
        n = 0;
        while (!clear_done && n < 2000) begin
            @(negedge clk_sys);
            n++;
            if (log_q.size() == 12 && !raised) begin
                host_req = 1'b1; host_we = 1'b0; host_addr = 27'h1000000; host_din = 16'd0;
                raised = 1'b1;
            end
            if (host_ack) begin
                check("A host_dout", 64'(host_dout), 64'd12345);
                @(posedge clk_sys);
                #1 host_req = 1'b0;
            end
        end
        check("A clear_done", 64'(clear_done), 64'd1);
        check("A cmd count at done", 64'(log_q.size()), 64'd24);
        if (log_q.size() == 24) begin
            for (int i = 7; i < 12; i++)
                check("A clear order pre", 64'(ent(i)), 64'({1'b1, 27'(i - 7), 16'd0}));
            check("A host slot", 64'(ent(12)), 64'({1'b0, 27'h1000000, 16'd0}));
            for (int i = 13; i < 24; i++)
                check("A clear order post", 64'(ent(i)), 64'({1'b1, 27'(i - 8), 16'd0}));
        end
        check("A ack count", 64'(ack_cnt), 64'd1);
        for (int i = 0; i < 16; i++)
            check("A mem zero", 64'(mm[idx(27'(i), 2'd0)]), 64'd0);
        repeat (10) @(negedge clk_sys);
        check("A idle hold", 64'({clear_done, mem_addr, mem_we, mem_rd}), 64'({1'b1, 27'd15, 2'b00}));

        // ---- B/C/D: aliasing decoders and dead data bus ----
        run_probe(2'd1, 16'h8003, "B");
        run_probe(2'd2, 16'h8001, "C");
        run_probe(2'd3, 16'h8000, "D");

        // ---- E: host write held off during probe, then reset mid-sweep ----
        host_req = 1'b1; host_we = 1'b1; host_addr = 27'h0000020; host_din = 16'hBEEF;
        run_probe(2'd0, 16'h8007, "E");
        check("E no ack in probe", 64'(ack_cnt), 64'd0);
        n = 0;
        while (!host_ack && n < 100) begin
            @(negedge clk_sys);
            n++;
        end
        check("E host ack", 64'(host_ack), 64'd1);
        @(posedge clk_sys);
        #1 host_req = 1'b0;
        n = 0;
        while (log_q.size() < 18 && n < 500) begin
            @(negedge clk_sys);
            n++;
        end
        check("E reach addr 9", 64'(log_q.size()), 64'd18);
        if (log_q.size() >= 18) begin
            check("E host first", 64'(ent(7)), 64'({1'b1, 27'h20, 16'hBEEF}));
            check("E clear addr0 next", 64'(ent(8)), 64'({1'b1, 27'd0, 16'd0}));
            check("E clear addr9", 64'(ent(17)), 64'({1'b1, 27'd9, 16'd0}));
        end
        check("E host mem", 64'(mm[idx(27'h20, 2'd0)]), 64'h0000BEEF);
        check("E ack count", 64'(ack_cnt), 64'd1);

        RESET = 1'b1;
        @(negedge clk_sys);
        check("E mid rst outputs", 64'({cfg, clear_done, mem_we, mem_rd, host_ack}), 64'd0);
        RESET = 1'b0;
        n = 0;
        while (!cfg[15] && n < 300) begin
            @(negedge clk_sys);
            n++;
        end
        check("E rerun cfg", 64'(cfg), 64'h8007);
        check("E rerun probe cmds", 64'(log_q.size()), 64'd7);
        n = 0;
        while (!clear_done && n < 2000) begin
            @(negedge clk_sys);
            n++;
        end
        check("E rerun clear cmds", 64'(log_q.size()), 64'd23);
        if (log_q.size() == 23) begin
            check("E rerun addr0", 64'(ent(7)), 64'({1'b1, 27'd0, 16'd0}));
            check("E rerun addr15", 64'(ent(22)), 64'({1'b1, 27'd15, 16'd0}));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
